dedicated_datapath: RTL and testbench

DEDICATED_DATAPATH -- requirements
Module: dedicated_datapath

---
 rtl/dp_pkg.sv | 12 +
 rtl/register_file.sv | 34 +++
 rtl/dedicated_datapath.sv | 62 ++++++
 tb/tb_dedicated_datapath.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// rtl/dp_pkg.sv - shared widths, register address type and write-source encodings
package dp_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int CMP_LIMIT_DEF = 10;

  typedef logic [2:0] reg_addr_t;

  localparam logic SRC_ADDER  = 1'b0;
  localparam logic SRC_CONST1 = 1'b1;

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - 8-entry register file, two combinational read ports, one write port
// R0 is hardwired to zero; no write-to-read bypass, so a same-cycle read sees the old value.
module register_file
  import dp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  reg_addr_t         read_addr1,
  input  reg_addr_t         read_addr2,
  input  reg_addr_t         write_addr,
  input  logic              write_en,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  logic [DATA_W-1:0] regs [8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en && (write_addr != 3'd0)) begin
      regs[write_addr] <= write_data;
    end
  end

  assign read_data1 = (read_addr1 == 3'd0) ? '0 : regs[read_addr1];
  assign read_data2 = (read_addr2 == 3'd0) ? '0 : regs[read_addr2];

endmodule

// File: rtl/dedicated_datapath.sv
// rtl/dedicated_datapath.sv - register file plus adder, write-source mux, limit compare and output register
// Sum wraps modulo 2^DATA_W; outValid marks the cycle in which a freshly loaded outPort is visible.
module dedicated_datapath
  import dp_pkg::*;
#(
  parameter int          DATA_W    = DATA_W_DEF,
  parameter int unsigned CMP_LIMIT = CMP_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RFSrcMuxSel,
  input  logic [2:0]        readAddr1,
  input  logic [2:0]        readAddr2,
  input  logic [2:0]        writeAddr,
  input  logic              writeEn,
  input  logic              outBuf,
  output logic              iLe10,
  output logic [DATA_W-1:0] outPort,
  output logic              outValid
);

  localparam logic [31:0]       CMP_LIMIT_U = CMP_LIMIT;
  localparam logic [DATA_W-1:0] ONE         = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] wdata;

  register_file #(
    .DATA_W(DATA_W)
  ) u_register_file (
    .clk       (clk),
    .reset     (reset),
    .read_addr1(readAddr1),
    .read_addr2(readAddr2),
    .write_addr(writeAddr),
    .write_en  (writeEn),
    .write_data(wdata),
    .read_data1(rdata1),
    .read_data2(rdata2)
  );

  assign sum   = rdata1 + rdata2;
  assign wdata = (RFSrcMuxSel == SRC_CONST1) ? ONE : sum;

  // Compare at 32 bits so the limit is never truncated to the datapath width.
  assign iLe10 = (32'(rdata1) <= CMP_LIMIT_U);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outPort  <= '0;
      outValid <= 1'b0;
    end else begin
      outValid <= outBuf;
      if (outBuf) begin
        outPort <= rdata1;
      end
    end
  end

endmodule

// File: tb/tb_dedicated_datapath.sv
// tb/tb_dedicated_datapath.sv - table vectors plus scoreboard for dedicated_datapath
module tb_dedicated_datapath;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       RFSrcMuxSel = 1'b0;
  logic [2:0] readAddr1 = 3'd0;
  logic [2:0] readAddr2 = 3'd0;
  logic [2:0] writeAddr = 3'd0;
  logic       writeEn = 1'b0;
  logic       outBuf = 1'b0;
  logic       iLe10;
  logic [7:0] outPort;
  logic       outValid;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int sb [$];

  typedef struct {
    int src; int ra1; int ra2; int wa; int we; int ob; int chk; int le; int rd1;
  } vec_t;

  vec_t vt [15];

  dedicated_datapath #(.DATA_W(8), .CMP_LIMIT(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .RFSrcMuxSel(RFSrcMuxSel),
    .readAddr1  (readAddr1),
    .readAddr2  (readAddr2),
    .writeAddr  (writeAddr),
    .writeEn    (writeEn),
    .outBuf     (outBuf),
    .iLe10      (iLe10),
    .outPort    (outPort),
    .outValid   (outValid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && outValid) begin
      pulses++;
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        check("outport", int'(outPort), sb.pop_front());
      end
    end
  end

  task automatic step(input int src, input int ra1, input int ra2, input int wa,
                      input int we, input int ob, input int chk, input int le, input int rd1);
    @(negedge clk);
    RFSrcMuxSel = 1'(src);
    readAddr1   = 3'(ra1);
    readAddr2   = 3'(ra2);
    writeAddr   = 3'(wa);
    writeEn     = 1'(we);
    outBuf      = 1'(ob);
    #1;
    if (chk != 0) check("ile10", int'(iLe10), le);
    if (ob != 0) sb.push_back(rd1);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_loop(input int n);
    step(1, 0, 0, 3, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 2, 1, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      step(0, 1, 0, 0, 0, 0, 1, 1, 0);
      step(0, 2, 1, 2, 1, 0, 0, 0, 0);
      step(0, 1, 3, 1, 1, 0, 0, 0, 0);
      step(0, 2, 0, 0, 0, 1, 0, 0, i * (i + 1) / 2);
    end
  endtask

  initial begin
    vt[0]  = '{1, 3, 0, 3, 1, 1, 1, 1, 0};
    vt[1]  = '{0, 3, 0, 0, 0, 1, 1, 1, 1};
    vt[2]  = '{0, 0, 0, 0, 0, 1, 1, 1, 0};
    vt[3]  = '{1, 0, 0, 0, 1, 0, 1, 1, 0};
    vt[4]  = '{0, 0, 0, 0, 0, 1, 1, 1, 0};
    vt[5]  = '{1, 1, 0, 1, 1, 0, 1, 1, 0};
    vt[6]  = '{0, 1, 1, 1, 1, 0, 1, 1, 1};
    vt[7]  = '{0, 1, 1, 4, 1, 0, 1, 1, 2};
    vt[8]  = '{0, 4, 4, 4, 1, 0, 1, 1, 4};
    vt[9]  = '{0, 4, 1, 1, 1, 0, 1, 1, 8};
    vt[10] = '{0, 1, 0, 0, 0, 1, 1, 1, 10};
    vt[11] = '{0, 1, 3, 1, 1, 0, 1, 1, 10};
    vt[12] = '{0, 1, 0, 0, 0, 1, 1, 0, 11};
    vt[13] = '{0, 0, 0, 1, 1, 0, 1, 1, 0};
    vt[14] = '{0, 1, 0, 0, 0, 1, 1, 1, 0};

    repeat (2) @(posedge clk);
    #1;
    check("reset_outport", int'(outPort), 0);
    check("reset_outvalid", int'(outValid), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 15; k++) begin
      step(vt[k].src, vt[k].ra1, vt[k].ra2, vt[k].wa, vt[k].we,
           vt[k].ob, vt[k].chk, vt[k].le, vt[k].rd1);
    end

    // Build 255 in R2 by repeated double-plus-one, then wrap it with +1.
    step(1, 2, 0, 2, 1, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) begin
      step(0, 2, 2, 2, 1, 0, 0, 0, 0);
      step(0, 2, 3, 2, 1, 0, 0, 0, 0);
    end
    step(0, 2, 0, 0, 0, 1, 1, 0, 255);
    step(0, 2, 3, 2, 1, 0, 1, 0, 0);
    step(0, 2, 0, 0, 0, 1, 1, 1, 0);
    idle();
    idle();
    check("sb_drained_a", sb.size(), 0);

    pulses = 0;
    run_loop(11);
    step(0, 1, 0, 0, 0, 0, 1, 0, 0);
    idle();
    idle();
    check("loop_final", int'(outPort), 55);
    check("loop_pulses", pulses, 11);
    check("sb_drained_b", sb.size(), 0);

    // Mid-loop asynchronous reset landing between clock edges.
    run_loop(6);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("midreset_outport", int'(outPort), 0);
    check("midreset_outvalid", int'(outValid), 0);
    check("midreset_r2_le", int'(iLe10), 1);
    sb.delete();
    RFSrcMuxSel = 1'b1;
    writeAddr   = 3'd4;
    writeEn     = 1'b1;
    outBuf      = 1'b0;
    readAddr1   = 3'd4;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_outport", int'(outPort), 0);
    @(negedge clk);
    writeEn = 1'b0;
    reset   = 1'b0;
    for (int r = 1; r < 8; r++) begin
      step(0, r, 0, 0, 0, 1, 1, 1, 0);
    end
    idle();
    idle();
    check("sb_drained_c", sb.size(), 0);

    pulses = 0;
    run_loop(11);
    step(0, 1, 0, 0, 0, 0, 1, 0, 0);
    idle();
    idle();
    check("restart_final", int'(outPort), 55);
    check("restart_pulses", pulses, 11);
    check("sb_drained_d", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
